// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and frame sizing.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // IDLE: line high | START: start bit | DATA: payload | PARITY: parity bit | STOP: stop bit(s)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: reloads to BAUD_COUNT-1 on load and ticks while enabled at count 0.
module uart_baud_gen #(
  parameter int BAUD_COUNT      = 104,
  parameter int BAUD_COUNT_SIZE = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  logic [BAUD_COUNT_SIZE-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= BAUD_COUNT_SIZE'(BAUD_COUNT - 1);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tick = i_en && (r_count == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stops.
// Optional macro UART_TX_BREAK_EN adds a brk input that holds the line low and aborts frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int BAUD_COUNT      = 104,
  parameter int BAUD_COUNT_SIZE = 7,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = PARITY_NONE,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 stb,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  logic [2:0]           r_state;
  logic                 r_busy;
  logic                 r_tx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [3:0]           r_bit_cnt;

  logic w_tick;
  logic w_accept;
  logic w_load;
  logic w_clr;
  logic w_last_data;
  logic w_last_stop;
  logic w_final;
  logic w_par_bit;

`ifdef UART_TX_BREAK_EN
  logic r_brk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brk <= 1'b0;
    end else begin
      r_brk <= brk;
    end
  end

  // ready stays low for one clock after brk falls so the line can return high first
  assign ready = !r_busy && !r_brk && !brk;
  assign w_clr = brk;
  assign done  = w_final && !brk;
`else
  assign ready = !r_busy;
  assign w_clr = 1'b0;
  assign done  = w_final;
`endif

  assign busy        = r_busy;
  assign tx          = r_tx;
  assign w_accept    = stb && ready;
  assign w_last_data = (r_bit_cnt == 4'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == 4'(STOP_BITS - 1));
  assign w_final     = r_busy && (r_state == ST_STOP) && w_last_stop && w_tick;
  assign w_load      = w_accept || (w_tick && !((r_state == ST_STOP) && w_last_stop));
  // r_par accumulates the XOR of the bits already shifted out of the latched word
  assign w_par_bit   = (PARITY == PARITY_EVEN) ? r_par : ~r_par;

  uart_baud_gen #(
    .BAUD_COUNT      (BAUD_COUNT),
    .BAUD_COUNT_SIZE (BAUD_COUNT_SIZE)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_load (w_load),
    .i_en   (r_busy),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
    end
`ifdef UART_TX_BREAK_EN
    else if (brk) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_tx      <= 1'b0;
      r_bit_cnt <= '0;
    end
`endif
    else if (w_accept) begin
      r_state   <= ST_START;
      r_busy    <= 1'b1;
      r_tx      <= 1'b0;
      r_shift   <= data;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_tick) begin
      case (r_state)
        ST_START: begin
          r_state   <= ST_DATA;
          r_tx      <= r_shift[0];
          r_par     <= r_par ^ r_shift[0];
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= '0;
        end
        ST_DATA: begin
          if (!w_last_data) begin
            r_tx      <= r_shift[0];
            r_par     <= r_par ^ r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end else if (PARITY != PARITY_NONE) begin
            r_state <= ST_PARITY;
            r_tx    <= w_par_bit;
          end else begin
            r_state   <= ST_STOP;
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        ST_PARITY: begin
          r_state   <= ST_STOP;
          r_tx      <= 1'b1;
          r_bit_cnt <= '0;
        end
        ST_STOP: begin
          if (w_last_stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
`ifdef UART_TX_BREAK_EN
    else if (!r_busy) begin
      r_tx <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7N2) at 4 clocks per bit,
// each checked every cycle against a per-clock queue of expected line levels.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int N  = 4;
  localparam int BC = 4;

  function automatic int db_of(input int k);
    return (k == 3) ? 7 : 8;
  endfunction

  function automatic int par_of(input int k);
    case (k)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int sb_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  logic       clk;
  logic       rst;
  logic       stb_v   [N];
  logic [8:0] data_v  [N];
  logic       brk_v   [N];
  logic       tx_v    [N];
  logic       busy_v  [N];
  logic       ready_v [N];
  logic       done_v  [N];

  int n_checks;
  int n_fail;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D = db_of(g);
    localparam int P = par_of(g);
    localparam int S = sb_of(g);

    uart_tx_frame #(
      .BAUD_COUNT      (BC),
      .BAUD_COUNT_SIZE (3),
      .DATA_BITS       (D),
      .PARITY          (P),
      .STOP_BITS       (S)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .data  (data_v[g][D-1:0]),
      .stb   (stb_v[g]),
`ifdef UART_TX_BREAK_EN
      .brk   (brk_v[g]),
`endif
      .ready (ready_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .tx    (tx_v[g])
    );

    // line[i] is the expected tx level i clocks from now while a frame is on the wire
    bit line [$];
    bit m_brk;
    int ones;
    bit exp_busy;
    bit exp_tx;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        line.delete();
        m_brk = 1'b0;
      end else begin
        if (brk_v[g]) begin
          line.delete();
        end else if (line.size() != 0) begin
          void'(line.pop_front());
        end else if (stb_v[g] && !m_brk) begin
          ones = 0;
          repeat (BC) line.push_back(1'b0);
          for (int i = 0; i < D; i++) begin
            ones += int'(data_v[g][i]);
            repeat (BC) line.push_back(data_v[g][i]);
          end
          if (P == 2) repeat (BC) line.push_back(ones % 2 == 1);
          else if (P == 1) repeat (BC) line.push_back(ones % 2 == 0);
          repeat (S * BC) line.push_back(1'b1);
        end
        m_brk = brk_v[g];
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        exp_busy = (line.size() != 0);
        exp_tx   = m_brk ? 1'b0 : (exp_busy ? line[0] : 1'b1);
        chk_eq($sformatf("tx%0d", g), tx_v[g], exp_tx);
        chk_eq($sformatf("busy%0d", g), busy_v[g], exp_busy);
        chk_eq($sformatf("ready%0d", g), ready_v[g], !exp_busy && !m_brk && !brk_v[g]);
        chk_eq($sformatf("done%0d", g), done_v[g], (line.size() == 1) && !brk_v[g]);
      end
    end
  end

  task automatic wait_busy(input int k, input logic lvl, input int budget);
    int n = 0;
    while (busy_v[k] !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk_eq($sformatf("wait_busy%0d_%0d", k, lvl), busy_v[k], lvl);
  endtask

  // Sends one word, jiggles stb/data during the frame, and checks length, mid-bit levels and done.
  task automatic send_frame(input int k, input logic [8:0] val, input int exp_len,
                            input logic [15:0] exp_bits);
    int c = 0;
    int ndone = 0;
    int done_at = -1;
    logic [15:0] got = '0;
    @(posedge clk); #2;
    stb_v[k]  = 1'b1;
    data_v[k] = val;
    @(posedge clk); #2;
    stb_v[k] = 1'b0;
    @(negedge clk);
    while (busy_v[k] && c < 400) begin
      if ((c % BC == 1) && (c / BC < 16)) got[c / BC] = tx_v[k];
      if (done_v[k]) begin
        ndone++;
        done_at = c;
      end
      c++;
      stb_v[k]  = (c < exp_len - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_v[k] = 9'($urandom);
      @(negedge clk);
    end
    chk_eq($sformatf("len%0d", k), c, exp_len);
    chk_eq($sformatf("bits%0d", k), got, exp_bits);
    chk_eq($sformatf("done_at%0d", k), done_at, exp_len - 1);
    chk_eq($sformatf("done_cnt%0d", k), ndone, 1);
    chk_eq($sformatf("end_ready%0d", k), ready_v[k], 1'b1);
    chk_eq($sformatf("end_tx%0d", k), tx_v[k], 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int k = 0; k < N; k++) begin
      stb_v[k]  = 1'b0;
      data_v[k] = '0;
      brk_v[k]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk_eq("rst_tx", tx_v[k], 1'b1);
      chk_eq("rst_busy", busy_v[k], 1'b0);
      chk_eq("rst_done", done_v[k], 1'b0);
      chk_eq("rst_ready", ready_v[k], 1'b1);
    end

    send_frame(0, 9'h0A5, 40, 16'({1'b1, 8'hA5, 1'b0}));
    send_frame(1, 9'h007, 44, 16'({1'b1, 1'b1, 8'h07, 1'b0}));
    send_frame(2, 9'h007, 44, 16'({1'b1, 1'b0, 8'h07, 1'b0}));
    send_frame(3, 9'h041, 40, 16'({2'b11, 7'h41, 1'b0}));

    // back-to-back with stb held high; mid-frame data changes must not leak into frame one
    @(posedge clk); #2;
    stb_v[0]  = 1'b1;
    data_v[0] = 9'h055;
    @(negedge clk);
    wait_busy(0, 1'b1, 8);
    repeat (5) @(posedge clk);
    #2 data_v[0] = 9'h033;
    repeat (15) @(posedge clk);
    #2 data_v[0] = 9'h0AA;
    @(negedge clk);
    wait_busy(0, 1'b0, 60);
    chk_eq("b2b_gap_ready", ready_v[0], 1'b1);
    chk_eq("b2b_gap_tx", tx_v[0], 1'b1);
    @(negedge clk);
    chk_eq("b2b_start_busy", busy_v[0], 1'b1);
    chk_eq("b2b_start_tx", tx_v[0], 1'b0);
    @(posedge clk); #2 stb_v[0] = 1'b0;
    @(negedge clk);
    wait_busy(0, 1'b0, 60);

    // asynchronous reset 13 clocks into a frame
    @(posedge clk); #2;
    stb_v[0]  = 1'b1;
    data_v[0] = 9'($urandom);
    @(posedge clk); #2 stb_v[0] = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    chk_eq("pre_rst_busy", busy_v[0], 1'b1);
    rst = 1'b1;
    #1;
    chk_eq("async_rst_tx", tx_v[0], 1'b1);
    chk_eq("async_rst_busy", busy_v[0], 1'b0);
    chk_eq("async_rst_done", done_v[0], 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

`ifdef UART_TX_BREAK_EN
    @(posedge clk); #2;
    stb_v[0]  = 1'b1;
    data_v[0] = 9'h0FF;
    @(posedge clk); #2 stb_v[0] = 1'b0;
    repeat (14) @(posedge clk);
    #2 brk_v[0] = 1'b1;
    @(negedge clk);
    chk_eq("brk_ready_now", ready_v[0], 1'b0);
    @(negedge clk);
    chk_eq("brk_tx", tx_v[0], 1'b0);
    chk_eq("brk_busy", busy_v[0], 1'b0);
    chk_eq("brk_ready", ready_v[0], 1'b0);
    repeat (4) @(posedge clk);
    #2 brk_v[0] = 1'b0;
    @(negedge clk);
    chk_eq("brk_fall_ready", ready_v[0], 1'b0);
    @(negedge clk);
    chk_eq("brk_rel_tx", tx_v[0], 1'b1);
    chk_eq("brk_rel_ready", ready_v[0], 1'b1);
`endif

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      for (int k = 0; k < N; k++) begin
        stb_v[k]  = ($urandom_range(0, 3) == 0);
        data_v[k] = 9'($urandom);
`ifdef UART_TX_BREAK_EN
        brk_v[k]  = ($urandom_range(0, 299) == 0) ? 1'b1 : (brk_v[k] && ($urandom_range(0, 3) != 0));
`endif
      end
    end
    @(posedge clk); #2;
    for (int k = 0; k < N; k++) begin
      stb_v[k] = 1'b0;
      brk_v[k] = 1'b0;
    end
    repeat (60) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) chk_eq("drain_busy", busy_v[k], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
